// File: rtl/bus_if_gen.sv
// bus_if_gen: pipeline-stage bus interface unit.
// Routes CPU-stage accesses to a zero-wait scratch-pad memory (SPM) or to the
// shared arbitrated bus, selected by the top SLV_IDX_W address bits. A read
// buffer keeps bus read data visible while the pipeline is stalled.
// Optional watchdog enabled by defining BUS_IF_TIMEOUT_EN: aborts a bus access
// that has not completed TIMEOUT cycles after entering REQ and pulses err.
module bus_if_gen #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned SLV_IDX_W = 3,
  parameter int unsigned SPM_IDX   = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  output logic              err,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy,
  input  logic              bus_grnt,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;

  localparam logic [SLV_IDX_W-1:0] SPM_SEL = SLV_IDX_W'(SPM_IDX);

  // A zero watchdog limit would abort every access in its first REQ cycle.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("bus_if_gen: TIMEOUT must be at least 1");
  end

  state_t            state_q;
  logic              bus_req_q;
  logic              bus_as_q;
  logic              bus_rw_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wr_data_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic              rd_hold_q;   // rd_buf holds read data for the HOLD state

  logic is_spm;
  logic done;
  logic expire;

  assign is_spm = (addr[ADDR_W-1 -: SLV_IDX_W] == SPM_SEL);
  assign done   = (state_q == ACCESS) && bus_rdy;

  // SPM side is a straight pass-through; only the strobe is qualified.
  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign bus_req     = bus_req_q;
  assign bus_as      = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

`ifdef BUS_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wdog_q;

  // Completion in the expiry cycle takes priority over the abort.
  assign expire = ((state_q == REQ) || (state_q == ACCESS)) &&
                  (wdog_q == CNT_W'(TIMEOUT)) && !done;

  // Watchdog: cleared when a bus access is accepted, counts REQ/ACCESS cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if ((state_q == IDLE) && as && !flush && !is_spm) begin
      wdog_q <= '0;
    end else if ((state_q == REQ) || (state_q == ACCESS)) begin
      wdog_q <= wdog_q + CNT_W'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Combinational handshake towards the pipeline stage; silent during reset.
  always_comb begin
    busy    = 1'b0;
    err     = 1'b0;
    spm_as  = 1'b0;
    rd_data = '0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (as && !flush) begin
            if (is_spm) begin
              if (!stall) begin
                spm_as = 1'b1;
                if (!rw) rd_data = spm_rd_data;
              end
            end else begin
              busy = 1'b1;
            end
          end
        end
        REQ: begin
          if (expire) err = 1'b1;
          else        busy = 1'b1;
        end
        ACCESS: begin
          if (bus_rdy) begin
            if (!bus_rw_q) rd_data = bus_rd_data;
          end else if (expire) begin
            err = 1'b1;
          end else begin
            busy = 1'b1;
          end
        end
        HOLD: begin
          if (rd_hold_q) rd_data = rd_buf_q;
        end
        default: ;
      endcase
    end
  end

  // Main FSM with registered bus-side outputs and the read buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_as_q      <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
      rd_hold_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (as && !flush && !is_spm) begin
            bus_req_q     <= 1'b1;
            bus_addr_q    <= addr;
            bus_rw_q      <= rw;
            bus_wr_data_q <= wr_data;
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (expire) begin
            bus_req_q     <= 1'b0;
            bus_as_q      <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_buf_q      <= '0;
            rd_hold_q     <= 1'b0;
            state_q       <= stall ? HOLD : IDLE;
          end else if (bus_grnt) begin
            bus_as_q <= 1'b1;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          bus_as_q <= 1'b0;
          if (bus_rdy || expire) begin
            if (bus_rdy && !bus_rw_q) rd_buf_q <= bus_rd_data;
            else if (!bus_rdy)        rd_buf_q <= '0;
            rd_hold_q     <= bus_rdy && !bus_rw_q;
            bus_req_q     <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            state_q       <= stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
